bullet_frame_scheduler: RTL and testbench

BULLET_FRAME_SCHEDULER -- requirements
Module: bullet_frame_scheduler

---
 rtl/bullet_frame_scheduler_pkg.sv | 37 +++
 rtl/bullet_frame_scheduler_if.sv | 27 ++
 rtl/bullet_frame_scheduler_box_overlap.sv | 19 +
 rtl/bullet_frame_scheduler.sv | 119 +++++++++++
 tb/tb_bullet_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bullet_frame_scheduler_pkg.sv
// Shared game definitions: FSM encoding, bullet colour codes and pos/size field layout.
// Imported by the scheduler, the bullet table and the renderer.
package bullet_frame_scheduler_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COLOR_WHITE    = 2'd0,
        COLOR_GREEN    = 2'd1,
        COLOR_BLUE     = 2'd2,
        COLOR_RESERVED = 2'd3
    } color_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pos_t;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
    } size_t;

    // Far edge of a box along one axis, widened so it never wraps.
    function automatic logic [8:0] far_edge(input logic [7:0] origin, input logic [7:0] extent);
        return {1'b0, origin} + {1'b0, extent};
    endfunction

endpackage

// File: rtl/bullet_frame_scheduler_if.sv
// Collision port between the frame scheduler (master) and the bullet table (slave).
interface bullet_frame_scheduler_if;
    logic [2:0]  slot_index;
    logic [15:0] slot_pos;
    logic [15:0] slot_size;
    logic [1:0]  slot_color;
    logic        slot_render;
    logic        collide;

    modport master (
        output slot_index,
        output collide,
        input  slot_pos,
        input  slot_size,
        input  slot_color,
        input  slot_render
    );

    modport slave (
        input  slot_index,
        input  collide,
        output slot_pos,
        output slot_size,
        output slot_color,
        output slot_render
    );
endinterface

// File: rtl/bullet_frame_scheduler_box_overlap.sv
// Combinational axis-aligned box intersection; edges that only touch do not overlap.
module box_overlap
    import bullet_frame_scheduler_pkg::*;
(
    input  pos_t  a_pos,
    input  size_t a_size,
    input  pos_t  b_pos,
    input  size_t b_size,
    output logic  hit
);

    always_comb begin
        hit = ({1'b0, b_pos.x} < far_edge(a_pos.x, a_size.w)) &&
              ({1'b0, a_pos.x} < far_edge(b_pos.x, b_size.w)) &&
              ({1'b0, b_pos.y} < far_edge(a_pos.y, a_size.h)) &&
              ({1'b0, a_pos.y} < far_edge(b_pos.y, b_size.h));
    end

endmodule

// File: rtl/bullet_frame_scheduler.sv
// Per-frame bullet collision scan: tests each bullet slot against the player,
// applies damage/heal to HP, then pulses run to advance the bullet field.
module bullet_frame_scheduler
    import bullet_frame_scheduler_pkg::*;
#(
    parameter int HP_MAX = 20,
    parameter int DMG    = 5,
    parameter int HEAL   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            enable,
    input  logic [15:0]                     player_pos,
    input  logic [15:0]                     player_size,
    input  logic                            player_moving,
    bullet_frame_scheduler_if.master        slots,
    output logic                            run,
    output logic [7:0]                      hp,
    output logic                            busy,
    output logic                            dead,
    output logic                            overrun
);

    localparam logic [7:0] HP_MAX_V = 8'(HP_MAX);
    localparam logic [7:0] DMG_V    = 8'(DMG);
    localparam logic [8:0] HEAL_V   = 9'(HEAL);

    state_t            state, state_next;
    logic [SLOT_W-1:0] idx, idx_next;
    logic [7:0]        hp_q, hp_next;
    logic              overrun_q, overrun_next;

    logic              overlap;
    logic              hit;
    logic              damaging;
    color_t            color;
    logic [7:0]        hp_dmg;
    logic [8:0]        hp_heal_raw;
    logic [7:0]        hp_heal;

    box_overlap u_box_overlap (
        .a_pos  (player_pos),
        .a_size (player_size),
        .b_pos  (slots.slot_pos),
        .b_size (slots.slot_size),
        .hit    (overlap)
    );

    always_comb begin
        color = color_t'(slots.slot_color);
        hit   = (state == ST_SCAN) && slots.slot_render && overlap &&
                ((color == COLOR_WHITE) || (color == COLOR_GREEN) ||
                 ((color == COLOR_BLUE) && player_moving));
        damaging    = hit && (color != COLOR_GREEN);
        hp_dmg      = (hp_q > DMG_V) ? (hp_q - DMG_V) : '0;
        hp_heal_raw = {1'b0, hp_q} + HEAL_V;
        hp_heal     = (hp_heal_raw > {1'b0, HP_MAX_V}) ? HP_MAX_V : hp_heal_raw[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hp_q      <= HP_MAX_V;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            hp_q      <= hp_next;
            overrun_q <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        hp_next      = hp_q;
        overrun_next = overrun_q;

        if (frame_tick && ((state == ST_SCAN) || (state == ST_ADVANCE))) begin
            overrun_next = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (frame_tick && enable) begin
                    state_next = ST_SCAN;
                    idx_next   = '0;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    hp_next = damaging ? hp_dmg : hp_heal;
                end
                // A lethal hit stops the scan on the hit slot; slot_index stays there.
                if (damaging && (hp_dmg == '0)) begin
                    state_next = ST_DEAD;
                end else if (idx == SLOT_W'(NUM_SLOTS - 1)) begin
                    state_next = ST_ADVANCE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_ADVANCE: state_next = ST_IDLE;
            ST_DEAD:    state_next = ST_DEAD;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign slots.slot_index = idx;
    assign slots.collide    = hit;
    assign run              = (state == ST_ADVANCE);
    assign busy             = (state == ST_SCAN) || (state == ST_ADVANCE);
    assign dead             = (state == ST_DEAD);
    assign hp               = hp_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_bullet_frame_scheduler.sv
// Directed bench for bullet_frame_scheduler: vector table of single-slot frames plus
// hand-written death, overrun, enable and reset sequences.
module tb_bullet_frame_scheduler;
    import bullet_frame_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        enable;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic        player_moving;
    logic        run;
    logic [7:0]  hp;
    logic        busy;
    logic        dead;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    bullet_frame_scheduler_if bus ();

    bullet_frame_scheduler #(
        .HP_MAX (20),
        .DMG    (5),
        .HEAL   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .enable        (enable),
        .player_pos    (player_pos),
        .player_size   (player_size),
        .player_moving (player_moving),
        .slots         (bus),
        .run           (run),
        .hp            (hp),
        .busy          (busy),
        .dead          (dead),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Bullet table model: combinational read at slot_index.
    logic [15:0] t_pos    [8];
    logic [15:0] t_size   [8];
    logic [1:0]  t_color  [8];
    logic        t_render [8];

    always_comb begin
        bus.slot_pos    = t_pos[bus.slot_index];
        bus.slot_size   = t_size[bus.slot_index];
        bus.slot_color  = t_color[bus.slot_index];
        bus.slot_render = t_render[bus.slot_index];
    end

    typedef struct {
        int          slot;
        bit          render;
        logic [1:0]  color;
        logic [15:0] bpos;
        logic [15:0] bsize;
        logic [15:0] ppos;
        logic [15:0] psize;
        bit          moving;
        int          pre;
        int          exp_coll;
        int          exp_hp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            t_pos[i] = '0; t_size[i] = '0; t_color[i] = '0; t_render[i] = 1'b0;
        end
    endtask

    task automatic set_slot(input int s, input logic [15:0] p, input logic [15:0] sz,
                            input logic [1:0] c, input bit r);
        t_pos[s] = p; t_size[s] = sz; t_color[s] = c; t_render[s] = r;
    endtask

    task automatic std_player();
        player_pos = {8'd50, 8'd50};
        player_size = {8'd16, 8'd16};
        player_moving = 1'b0;
    endtask

    // Tick, then observe 12 cycles; k counts cycles after the tick was sampled.
    task automatic run_frame(output int n_coll, output int coll_idx, output int run_k, output int run_cnt);
        n_coll = 0; coll_idx = -1; run_k = -1; run_cnt = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (bus.collide) begin n_coll++; coll_idx = int'(bus.slot_index); end
            if (run) begin run_cnt++; run_k = k; end
        end
    endtask

    task automatic pre_hit();
        int a, b, c, d;
        clear_table();
        std_player();
        set_slot(2, {8'd60, 8'd60}, {8'd4, 8'd4}, 2'd0, 1'b1);
        run_frame(a, b, c, d);
    endtask

    initial begin
        int nc, ci, rk, rc;
        int dead_k, hp_before, busy_cnt;
        rst = 1'b1; frame_tick = 1'b0; enable = 1'b1;
        std_player();
        clear_table();

        vecs[0]  = '{2, 1, 2'd0, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 1, 15};
        vecs[1]  = '{2, 1, 2'd2, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 0, 20};
        vecs[2]  = '{2, 1, 2'd2, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 1, 0, 1, 15};
        vecs[3]  = '{5, 1, 2'd1, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 1, 20};
        vecs[4]  = '{5, 1, 2'd1, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 1, 1, 16};
        vecs[5]  = '{0, 1, 2'd0, {8'd66,8'd50},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 0, 20};
        vecs[6]  = '{0, 1, 2'd0, {8'd65,8'd50},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 1, 15};
        vecs[7]  = '{7, 1, 2'd0, {8'd255,8'd255}, {8'd4,8'd4}, {8'd250,8'd250}, {8'd10,8'd10}, 0, 0, 1, 15};
        vecs[8]  = '{7, 1, 2'd0, {8'd1,8'd1},     {8'd4,8'd4}, {8'd250,8'd250}, {8'd10,8'd10}, 0, 0, 0, 20};
        vecs[9]  = '{3, 1, 2'd3, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 0, 20};
        vecs[10] = '{3, 0, 2'd0, {8'd60,8'd60},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 0, 20};
        vecs[11] = '{4, 1, 2'd0, {8'd50,8'd66},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 0, 20};
        vecs[12] = '{4, 1, 2'd0, {8'd47,8'd47},   {8'd4,8'd4}, {8'd50,8'd50},   {8'd16,8'd16}, 0, 0, 1, 15};

        // Reset state
        do_reset();
        check("rst_hp", int'(hp), 20);
        check("rst_dead", int'(dead), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_run", int'(run), 0);
        check("rst_collide", int'(bus.collide), 0);
        check("rst_index", int'(bus.slot_index), 0);

        for (int v = 0; v < 13; v++) begin
            do_reset();
            for (int p = 0; p < vecs[v].pre; p++) pre_hit();
            clear_table();
            player_pos = vecs[v].ppos;
            player_size = vecs[v].psize;
            player_moving = vecs[v].moving;
            set_slot(vecs[v].slot, vecs[v].bpos, vecs[v].bsize, vecs[v].color, vecs[v].render);
            run_frame(nc, ci, rk, rc);
            check($sformatf("v%0d_collide_count", v), nc, vecs[v].exp_coll);
            if (vecs[v].exp_coll != 0) check($sformatf("v%0d_collide_index", v), ci, vecs[v].slot);
            check($sformatf("v%0d_hp", v), int'(hp), vecs[v].exp_hp);
            check($sformatf("v%0d_run_latency", v), rk, 9);
            check($sformatf("v%0d_run_pulses", v), rc, 1);
            check($sformatf("v%0d_idle_busy", v), int'(busy), 0);
        end

        // Lethal hit on slot 3 with another live bullet on slot 5
        do_reset();
        for (int p = 0; p < 3; p++) pre_hit();
        check("death_pre_hp", int'(hp), 5);
        clear_table();
        std_player();
        set_slot(3, {8'd60, 8'd60}, {8'd4, 8'd4}, 2'd0, 1'b1);
        set_slot(5, {8'd60, 8'd60}, {8'd4, 8'd4}, 2'd0, 1'b1);
        nc = 0; ci = -1; rc = 0; dead_k = -1; hp_before = -1;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (bus.collide) begin nc++; ci = int'(bus.slot_index); hp_before = int'(hp); end
            if (run) rc++;
            if (dead && dead_k < 0) dead_k = k;
        end
        check("death_collide_count", nc, 1);
        check("death_collide_index", ci, 3);
        check("death_hp_before", hp_before, 5);
        check("death_edge", dead_k, 5);
        check("death_run", rc, 0);
        check("death_hp", int'(hp), 0);
        check("death_index_hold", int'(bus.slot_index), 3);
        busy_cnt = 0; rc = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (busy) busy_cnt++;
            if (run) rc++;
        end
        check("dead_tick_busy", busy_cnt, 0);
        check("dead_tick_run", rc, 0);
        check("dead_sticky", int'(dead), 1);
        check("dead_index", int'(bus.slot_index), 3);

        // Tick while scanning sets overrun without disturbing the frame
        do_reset();
        clear_table();
        std_player();
        set_slot(2, {8'd60, 8'd60}, {8'd4, 8'd4}, 2'd0, 1'b1);
        nc = 0; rk = -1; rc = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = (k == 3);
            if (bus.collide) nc++;
            if (run) begin rc++; rk = k; end
        end
        check("ovr_flag", int'(overrun), 1);
        check("ovr_run_latency", rk, 9);
        check("ovr_run_pulses", rc, 1);
        check("ovr_hp", int'(hp), 15);
        check("ovr_collide_count", nc, 1);

        // Reset mid-scan at slot 4
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (busy && bus.slot_index == 3'd4) break;
        end
        check("midrst_pre_hp", int'(hp), 10);
        check("midrst_pre_index", int'(bus.slot_index), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_hp", int'(hp), 20);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_index", int'(bus.slot_index), 0);
        check("midrst_run", int'(run), 0);

        // Dropping enable mid-frame only blocks the next start
        do_reset();
        clear_table();
        rk = -1;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (k == 3) enable = 1'b0;
            if (run) rk = k;
        end
        check("en_mid_run_latency", rk, 9);
        busy_cnt = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (busy) busy_cnt++;
        end
        check("en_low_no_start", busy_cnt, 0);
        enable = 1'b1;

        // Reset wins over a simultaneous tick
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
        check("rst_vs_tick_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_vs_tick_busy_after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
